// File: rtl/moxie_wb_ram.sv
// Wishbone classic-cycle RAM responder: latches one request, waits a fixed number of cycles,
// then acks for one cycle with read data or commits the byte-enabled write.
module moxie_wb_ram #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StAck  = 2'd2;

  localparam int unsigned Depth    = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  WaitInit = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [31:0] mem [Depth];

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q;
  logic [3:0]            sel_q;
  logic [31:0]           dat_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  ack_q;
  logic [31:0]           rdata_q;

  logic                  req;
  logic                  accept;
  logic                  enter_ack;
  logic                  x_we;
  logic [3:0]            x_sel;
  logic [31:0]           x_dat;
  logic [ADDR_WIDTH-1:0] x_idx;
  logic                  unused_adr;

  assign req        = wb_cyc_i & wb_stb_i;
  assign accept     = (state_q == StIdle) && req;
  assign unused_adr = ^{wb_adr_i[31:ADDR_WIDTH+2], wb_adr_i[1:0]};

  // With zero wait states ACK is entered straight from IDLE, before the latch is loaded,
  // so the live bus inputs must feed the RAM on that edge.
  always_comb begin
    if (state_q == StIdle) begin
      x_we  = wb_we_i;
      x_sel = wb_sel_i;
      x_dat = wb_dat_i;
      x_idx = wb_adr_i[ADDR_WIDTH+1:2];
    end else begin
      x_we  = we_q;
      x_sel = sel_q;
      x_dat = dat_q;
      x_idx = idx_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end else begin
            state_d = StAck;
          end
        end
      end
      StWait: begin
        if (!wb_cyc_i) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // ACK always returns to IDLE, so any next state of ACK is a fresh entry.
  assign enter_ack = (state_d == StAck);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= enter_ack;
      rdata_q <= (enter_ack && !x_we) ? mem[x_idx] : 32'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q  <= wb_we_i;
      sel_q <= wb_sel_i;
      dat_q <= wb_dat_i;
      idx_q <= wb_adr_i[ADDR_WIDTH+1:2];
    end
  end

  // sel[3] maps to dat[31:24], so byte lane i is simply bits [8i+7:8i].
  always_ff @(posedge clk_i) begin
    if (!rst_i && enter_ack && x_we) begin
      for (int i = 0; i < 4; i++) begin
        if (x_sel[i]) begin
          mem[x_idx][8*i +: 8] <= x_dat[8*i +: 8];
        end
      end
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = rdata_q;

endmodule

// File: tb/tb_moxie_wb_ram.sv
// Bench for moxie_wb_ram: three instances (1, 3 and 0 wait states) checked against a
// word-array model of the RAM with byte merging and address aliasing.
module tb_moxie_wb_ram;

  logic        clk;
  logic [2:0]  rst;
  logic [2:0]  cyc;
  logic [2:0]  stb;
  logic [2:0]  we_s;
  logic [31:0] adr_s [3];
  logic [3:0]  sel_s [3];
  logic [31:0] dat_s [3];
  logic [31:0] rdat0, rdat1, rdat2;
  logic        ack0, ack1, ack2;
  logic [31:0] rd [3];
  logic [2:0]  ack;

  int pass_cnt;
  int total_cnt;

  logic [31:0] mdl [int];

  always_comb begin
    rd[0] = rdat0;
    rd[1] = rdat1;
    rd[2] = rdat2;
    ack   = {ack2, ack1, ack0};
  end

  moxie_wb_ram #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_dut0 (
    .clk_i(clk), .rst_i(rst[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we_s[0]),
    .wb_adr_i(adr_s[0]), .wb_sel_i(sel_s[0]), .wb_dat_i(dat_s[0]), .wb_dat_o(rdat0),
    .wb_ack_o(ack0)
  );
  moxie_wb_ram #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we_s[1]),
    .wb_adr_i(adr_s[1]), .wb_sel_i(sel_s[1]), .wb_dat_i(dat_s[1]), .wb_dat_o(rdat1),
    .wb_ack_o(ack1)
  );
  moxie_wb_ram #(.ADDR_WIDTH(4), .WAIT_STATES(0)) u_dut2 (
    .clk_i(clk), .rst_i(rst[2]), .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]), .wb_we_i(we_s[2]),
    .wb_adr_i(adr_s[2]), .wb_sel_i(sel_s[2]), .wb_dat_i(dat_s[2]), .wb_dat_o(rdat2),
    .wb_ack_o(ack2)
  );

  always #5 clk = ~clk;

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 0;
  endfunction

  // Model key: instance number plus word index after dropping byte offset and aliased bits.
  function automatic int key_of(input int d, input logic [31:0] adr);
    int aw;
    aw = (d == 2) ? 4 : 10;
    return d * 65536 + int'((adr >> 2) % (32'd1 << aw));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  // Called and returns #1 after a rising edge. Scrambles the bus while waiting for ack.
  task automatic xfer(input int d, input bit we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, output bit got, output int lat,
                      output logic [31:0] rdata, output bit leak, output bit ack_after);
    got = 0; lat = 0; leak = 0; rdata = 32'd0; ack_after = 0;
    cyc[d] = 1'b1; stb[d] = 1'b1; we_s[d] = we;
    adr_s[d] = adr; sel_s[d] = sel; dat_s[d] = dat;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (ack[d]) begin
        got   = 1;
        rdata = rd[d];
      end else begin
        if (rd[d] !== 32'd0) leak = 1;
        adr_s[d] = $urandom; dat_s[d] = $urandom;
        sel_s[d] = 4'($urandom); we_s[d] = 1'($urandom);
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
    @(posedge clk); #1;
    ack_after = ack[d];
    if (rd[d] !== 32'd0) leak = 1;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      total_cnt++;
      if (ack[d] !== 1'b0 || rd[d] !== 32'd0)
        $display("FAIL reset_%0d: ack=%b dat=%h required ack=0 dat=0", d, ack[d], rd[d]);
      else pass_cnt++;
    end
  endtask

  task automatic test_write_read();
    bit got, leak, aa; int lat; logic [31:0] r;
    xfer(0, 1, 32'h10, 4'hF, 32'h1234_5678, got, lat, r, leak, aa);
    mdl[key_of(0, 32'h10)] = 32'h1234_5678;
    total_cnt++;
    if (!got || lat != 2 || aa)
      $display("FAIL wr_ack: got=%0b lat=%0d ack_after=%0b required 1/2/0", got, lat, aa);
    else pass_cnt++;
    xfer(0, 0, 32'h10, 4'hF, 32'h0, got, lat, r, leak, aa);
    total_cnt++;
    if (r !== 32'h1234_5678 || lat != 2 || leak || aa)
      $display("FAIL rd_data: dat=%h lat=%0d leak=%0b ack_after=%0b required 12345678/2/0/0",
               r, lat, leak, aa);
    else pass_cnt++;
  endtask

  task automatic test_byte_enables();
    bit got, leak, aa; int lat; logic [31:0] r;
    xfer(0, 1, 32'h44, 4'hF, 32'hAABB_CCDD, got, lat, r, leak, aa);
    xfer(0, 1, 32'h44, 4'b1001, 32'h1122_3344, got, lat, r, leak, aa);
    xfer(0, 0, 32'h44, 4'h0, 32'h0, got, lat, r, leak, aa);
    total_cnt++;
    if (r !== 32'h11BB_CC44) $display("FAIL byte_en: dat=%h required 11bbcc44", r);
    else pass_cnt++;
    xfer(0, 1, 32'h44, 4'h0, 32'hFFFF_FFFF, got, lat, r, leak, aa);
    total_cnt++;
    if (!got) $display("FAIL sel0_ack: got=%0b required 1", got);
    else pass_cnt++;
    xfer(0, 0, 32'h44, 4'h6, 32'h0, got, lat, r, leak, aa);
    total_cnt++;
    if (r !== 32'h11BB_CC44) $display("FAIL sel0_nowrite: dat=%h required 11bbcc44", r);
    else pass_cnt++;
    mdl[key_of(0, 32'h44)] = 32'h11BB_CC44;
  endtask

  // Random traffic over 16 words with random upper/low address bits to exercise aliasing.
  task automatic test_random(input int d, input int n_ops);
    bit got, leak, aa; int lat; logic [31:0] r, a, w; logic [3:0] s; bit we;
    for (int i = 0; i < 16; i++) begin
      a = ($urandom & 32'hFFFF_F000) | (32'(i) << 2) | ($urandom & 32'h3);
      if (d == 2) a = $urandom;
      w = $urandom;
      xfer(d, 1, a, 4'hF, w, got, lat, r, leak, aa);
      if (got) mdl[key_of(d, a)] = w;
    end
    for (int i = 0; i < n_ops; i++) begin
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'h3);
      if (d == 2) a = $urandom;
      w = $urandom; s = 4'($urandom); we = 1'($urandom);
      xfer(d, we, a, s, w, got, lat, r, leak, aa);
      total_cnt++;
      if (!got || lat != wait_of(d) + 1 || aa || leak) begin
        $display("FAIL rand_ack_%0d: got=%0b lat=%0d ack_after=%0b leak=%0b required 1/%0d/0/0",
                 d, got, lat, aa, leak, wait_of(d) + 1);
      end else pass_cnt++;
      if (we) begin
        mdl[key_of(d, a)] = merge(mdl[key_of(d, a)], w, s);
      end else begin
        total_cnt++;
        if (r !== mdl[key_of(d, a)])
          $display("FAIL rand_rd_%0d: adr=%h dat=%h required %h", d, a, r, mdl[key_of(d, a)]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_abort();
    bit got, leak, aa; int lat, n_ack; logic [31:0] r;
    xfer(1, 1, 32'h80, 4'hF, 32'hCAFE_F00D, got, lat, r, leak, aa);
    total_cnt++;
    if (!got || lat != 4) $display("FAIL wait3_lat: got=%0b lat=%0d required 1/4", got, lat);
    else pass_cnt++;
    cyc[1] = 1'b1; stb[1] = 1'b1; we_s[1] = 1'b1;
    adr_s[1] = 32'h80; sel_s[1] = 4'hF; dat_s[1] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    cyc[1] = 1'b0;
    n_ack = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ack[1]) n_ack++;
    end
    stb[1] = 1'b0;
    total_cnt++;
    if (n_ack != 0) $display("FAIL abort_ack: acks=%0d required 0", n_ack);
    else pass_cnt++;
    xfer(1, 0, 32'h80, 4'hF, 32'h0, got, lat, r, leak, aa);
    total_cnt++;
    if (r !== 32'hCAFE_F00D) $display("FAIL abort_data: dat=%h required cafef00d", r);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit got, leak, aa; int lat, n, cnt; logic [31:0] r;
    int at [3]; logic [31:0] dv [3]; logic [31:0] ev [3];
    for (int i = 0; i < 3; i++) begin
      ev[i] = $urandom;
      xfer(0, 1, 32'(i * 4), 4'hF, ev[i], got, lat, r, leak, aa);
      at[i] = 0; dv[i] = 32'd0;
    end
    cyc[0] = 1'b1; stb[0] = 1'b1; we_s[0] = 1'b0; adr_s[0] = 32'h0; sel_s[0] = 4'hF;
    n = 0; cnt = 0;
    while (n < 3 && cnt < 60) begin
      @(posedge clk); #1;
      cnt++;
      if (ack[0]) begin
        at[n] = cnt; dv[n] = rd[0]; n++;
        adr_s[0] = 32'(n * 4);
      end
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (n != 3 || at[0] != 2)
      $display("FAIL b2b_count: acks=%0d first=%0d required 3/2", n, at[0]);
    else pass_cnt++;
    for (int i = 1; i < 3; i++) begin
      total_cnt++;
      if (at[i] - at[i-1] != 3)
        $display("FAIL b2b_gap_%0d: gap=%0d required 3", i, at[i] - at[i-1]);
      else pass_cnt++;
    end
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (dv[i] !== ev[i]) $display("FAIL b2b_data_%0d: dat=%h required %h", i, dv[i], ev[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    bit got, leak, aa; int lat; logic [31:0] r;
    xfer(0, 1, 32'h20, 4'hF, 32'h5555_AAAA, got, lat, r, leak, aa);
    cyc[0] = 1'b1; stb[0] = 1'b1; we_s[0] = 1'b1;
    adr_s[0] = 32'h20; sel_s[0] = 4'hF; dat_s[0] = 32'h0F0F_0F0F;
    @(posedge clk); #1;
    rst[0] = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (ack[0] !== 1'b0 || rd[0] !== 32'd0)
      $display("FAIL rst_mid: ack=%b dat=%h required 0/0", ack[0], rd[0]);
    else pass_cnt++;
    rst[0] = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (ack[0] !== 1'b0) $display("FAIL rst_after: ack=%b required 0", ack[0]);
    else pass_cnt++;
    xfer(0, 0, 32'h20, 4'hF, 32'h0, got, lat, r, leak, aa);
    total_cnt++;
    if (r !== 32'h5555_AAAA) $display("FAIL rst_data: dat=%h required 5555aaaa", r);
    else pass_cnt++;
  endtask

  task automatic test_zero_wait();
    bit got, leak, aa; int lat; logic [31:0] r;
    xfer(2, 1, 32'h40, 4'hF, 32'h0BAD_CAFE, got, lat, r, leak, aa);
    total_cnt++;
    if (!got || lat != 1 || aa)
      $display("FAIL ws0_wr: got=%0b lat=%0d ack_after=%0b required 1/1/0", got, lat, aa);
    else pass_cnt++;
    xfer(2, 0, 32'h00, 4'hF, 32'h0, got, lat, r, leak, aa);
    total_cnt++;
    if (r !== 32'h0BAD_CAFE || lat != 1)
      $display("FAIL ws0_alias: dat=%h lat=%0d required 0badcafe/1", r, lat);
    else pass_cnt++;
  endtask

  initial begin
    clk = 1'b0; rst = 3'b111; cyc = '0; stb = '0; we_s = '0;
    pass_cnt = 0; total_cnt = 0;
    for (int d = 0; d < 3; d++) begin
      adr_s[d] = 32'd0; sel_s[d] = 4'd0; dat_s[d] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 3'b000;
    @(posedge clk); #1;
    test_reset();
    test_write_read();
    test_byte_enables();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_zero_wait();
    test_random(0, 40);
    test_random(1, 15);
    test_random(2, 30);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
